// File: rtl/shift_sequencer.sv
// Rotating LED shift-register controller: owns the register and its step prescaler,
// and takes load/run/stop/step commands over a valid/ready port.
module shift_sequencer #(
    parameter int          W   = 8,
    parameter int          NP  = 21,
    parameter logic [W-1:0] INI = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [7:0]   cmd_arg,
    output logic [W-1:0] data,
    output logic         step,
    output logic         busy
);

    localparam int FW = NP - 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN_FREE, S_RUN_BOUNDED} state_t;
    typedef enum logic [1:0] {M_ROT_L, M_ROT_R, M_BOUNCE} mode_t;
    typedef enum logic {DIR_L, DIR_R} dir_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD, OP_ROT_L, OP_ROT_R, OP_BOUNCE, OP_STOP, OP_SET_DIV, OP_STEP
    } op_t;

    state_t        state;
    mode_t         mode;
    dir_t          dir;
    logic [7:0]    div;
    logic [7:0]    remaining;
    logic [FW-1:0] fine;
    logic [7:0]    coarse;

    logic          accept;
    logic          tick;
    dir_t          nxt_dir;
    logic          rot_left;
    logic [W-1:0]  nxt_data;

    assign cmd_ready = !rst && (state != S_RUN_BOUNDED);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (state != S_IDLE) && (&fine) && (coarse == div);

    // Bounce evaluates the end-stop flip before rotating, so the step leaving an end already moves back.
    always_comb begin
        nxt_dir = dir;
        if (mode == M_BOUNCE) begin
            if (dir == DIR_L && data[W-1])
                nxt_dir = DIR_R;
            else if (dir == DIR_R && data[0])
                nxt_dir = DIR_L;
        end
        rot_left = (mode == M_ROT_L) || (mode == M_BOUNCE && nxt_dir == DIR_L);
        nxt_data = rot_left ? {data[W-2:0], data[W-1]} : {data[0], data[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= INI;
            dir       <= DIR_L;
            mode      <= M_ROT_L;
            div       <= 8'hFF;
            state     <= S_IDLE;
            remaining <= '0;
            fine      <= '0;
            coarse    <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            step <= 1'b0;

            if (state == S_IDLE || tick) begin
                fine   <= '0;
                coarse <= '0;
            end else begin
                fine <= fine + 1'b1;
                if (&fine)
                    coarse <= coarse + 8'd1;
            end

            // Any accepted command swallows a coincident tick; later clears here override the counter update above.
            if (accept) begin
                case (op_t'(cmd_op))
                    OP_LOAD: data <= W'(cmd_arg);
                    OP_ROT_L, OP_ROT_R, OP_BOUNCE: begin
                        if (op_t'(cmd_op) == OP_ROT_L) begin
                            mode <= M_ROT_L;
                            dir  <= DIR_L;
                        end else if (op_t'(cmd_op) == OP_ROT_R) begin
                            mode <= M_ROT_R;
                            dir  <= DIR_R;
                        end else begin
                            mode <= M_BOUNCE;
                        end
                        fine   <= '0;
                        coarse <= '0;
                        busy   <= 1'b1;
                        if (cmd_arg == 8'd0) begin
                            state <= S_RUN_FREE;
                        end else begin
                            remaining <= cmd_arg;
                            state     <= S_RUN_BOUNDED;
                        end
                    end
                    OP_STOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    OP_SET_DIV: begin
                        div    <= cmd_arg;
                        fine   <= '0;
                        coarse <= '0;
                    end
                    OP_STEP: begin
                        if (state == S_IDLE) begin
                            data <= nxt_data;
                            dir  <= nxt_dir;
                            step <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (tick) begin
                data <= nxt_data;
                dir  <= nxt_dir;
                step <= 1'b1;
                if (state == S_RUN_BOUNDED) begin
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
